osc_sched: RTL and testbench

OSC_SCHED -- requirements
Module: osc_sched

---
 rtl/osc_pkg.sv | 34 +++
 rtl/osc_step.sv | 37 +++
 rtl/osc_sched.sv | 110 +++++++++++
 tb/tb_osc_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared constants, register map and types for the three-voice oscillator scheduler.
package osc_pkg;
   localparam int NUM_VOICES   = 3;
   localparam int VOICE_STRIDE = 7;
   localparam int ACC_W        = 24;
   localparam int LFSR_W       = 23;
   localparam int NOISE_W      = 12;
   localparam int PW_W         = 12;

   localparam int OFF_FREQ_LO  = 0;
   localparam int OFF_FREQ_HI  = 1;
   localparam int OFF_PW_LO    = 2;
   localparam int OFF_PW_HI    = 3;
   localparam int OFF_CTRL     = 4;

   localparam int CTRL_SYNC_BIT = 1;
   localparam int CTRL_TEST_BIT = 3;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_V0,
      ST_V1,
      ST_V2,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [15:0]     freq;
      logic [PW_W-1:0] pw;
      logic [7:0]      ctrl;
   } voice_regs_t;
endpackage

// File: rtl/osc_step.sv
// One voice's next-state: accumulator, noise LFSR and MSB-rise flag.
module osc_step
   import osc_pkg::*;
(
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [LFSR_W-1:0] lfsr_i,
   input  logic [15:0]       freq_i,
   input  logic [7:0]        ctrl_i,
   input  logic              sync_in_i,
   output logic [ACC_W-1:0]  acc_o,
   output logic [LFSR_W-1:0] lfsr_o,
   output logic              rise_o
);
   logic [ACC_W-1:0] sum;
   logic             test, sync;
   logic             unused_ctrl;

   assign unused_ctrl = ^{ctrl_i[7:4], ctrl_i[2], ctrl_i[0]};
   assign test        = ctrl_i[CTRL_TEST_BIT];
   assign sync        = ctrl_i[CTRL_SYNC_BIT];
   assign sum         = acc_i + {{(ACC_W-16){1'b0}}, freq_i};

   always_comb begin
      acc_o  = sum;
      lfsr_o = lfsr_i;
      if (test) begin
         acc_o  = '0;
         lfsr_o = LFSR_SEED;
      end else if (sync && sync_in_i) begin
         acc_o = '0;
      end else if (!acc_i[19] && sum[19]) begin
         lfsr_o = {lfsr_i[LFSR_W-2:0], lfsr_i[22] ^ lfsr_i[17]};
      end
      // A cleared accumulator can never produce a rise, so one expression covers all rules.
      rise_o = !acc_i[ACC_W-1] && acc_o[ACC_W-1];
   end
endmodule

// File: rtl/osc_sched.sv
// Frame scheduler: on each tick, walks V0..V2 through one shared osc_step, then pulses frame_done.
module osc_sched
   import osc_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               tick,
   input  logic                               wr_en,
   input  logic [4:0]                         wr_addr,
   input  logic [7:0]                         wr_data,
   output logic [NUM_VOICES-1:0][ACC_W-1:0]   phase,
   output logic [NUM_VOICES-1:0]              pulse,
   output logic [NUM_VOICES-1:0][NOISE_W-1:0] noise,
   output logic                               busy,
   output logic                               frame_done,
   output logic                               overrun
);
   state_e                            state_q, state_d;
   voice_regs_t [NUM_VOICES-1:0]      regs_q;
   logic [NUM_VOICES-1:0][ACC_W-1:0]  acc_q;
   logic [NUM_VOICES-1:0][LFSR_W-1:0] lfsr_q;
   logic [NUM_VOICES-1:0]             rise_q;
   logic                              overrun_q;
   logic                              upd_en;
   logic [1:0]                        vsel, src;
   logic [ACC_W-1:0]                  acc_nx;
   logic [LFSR_W-1:0]                 lfsr_nx;
   logic                              rise_nx;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (tick) state_d = ST_V0;
         ST_V0:   state_d = ST_V1;
         ST_V1:   state_d = ST_V2;
         ST_V2:   state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
      upd_en     = 1'b0;
      vsel       = 2'd0;
      case (state_q)
         ST_V0:   begin upd_en = 1'b1; vsel = 2'd0; end
         ST_V1:   begin upd_en = 1'b1; vsel = 2'd1; end
         ST_V2:   begin upd_en = 1'b1; vsel = 2'd2; end
         default: ;
      endcase
   end

   // Sync ring: each voice is reset by its predecessor, voice 0 by voice 2.
   assign src = (vsel == 2'd0) ? 2'(NUM_VOICES-1) : vsel - 2'd1;

   osc_step u_step (
      .acc_i     (acc_q[vsel]),
      .lfsr_i    (lfsr_q[vsel]),
      .freq_i    (regs_q[vsel].freq),
      .ctrl_i    (regs_q[vsel].ctrl),
      .sync_in_i (rise_q[src]),
      .acc_o     (acc_nx),
      .lfsr_o    (lfsr_nx),
      .rise_o    (rise_nx)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            acc_q[v]  <= '0;
            lfsr_q[v] <= LFSR_SEED;
         end
         rise_q <= '0;
      end else if (upd_en) begin
         acc_q[vsel]  <= acc_nx;
         lfsr_q[vsel] <= lfsr_nx;
         rise_q[vsel] <= rise_nx;
      end

   // Addresses with no matching voice/offset (reserved slots, 21-31) fall through untouched.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         regs_q <= '0;
      end else if (wr_en) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (wr_addr == 5'(v*VOICE_STRIDE + OFF_FREQ_LO)) regs_q[v].freq[7:0]  <= wr_data;
            if (wr_addr == 5'(v*VOICE_STRIDE + OFF_FREQ_HI)) regs_q[v].freq[15:8] <= wr_data;
            if (wr_addr == 5'(v*VOICE_STRIDE + OFF_PW_LO))   regs_q[v].pw[7:0]    <= wr_data;
            if (wr_addr == 5'(v*VOICE_STRIDE + OFF_PW_HI))   regs_q[v].pw[11:8]   <= wr_data[3:0];
            if (wr_addr == 5'(v*VOICE_STRIDE + OFF_CTRL))    regs_q[v].ctrl       <= wr_data;
         end
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst)                           overrun_q <= 1'b0;
      else if (tick && state_q != ST_IDLE) overrun_q <= 1'b1;

   assign overrun = overrun_q;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
      assign phase[v] = acc_q[v];
      assign noise[v] = lfsr_q[v][LFSR_W-1 -: NOISE_W];
      assign pulse[v] = acc_q[v][ACC_W-1 -: PW_W] >= regs_q[v].pw;
   end
endmodule

// File: tb/tb_osc_sched.sv
// Randomized and directed checks of osc_sched against a frame-level reference model.
module tb_osc_sched;
   logic              clk = 1'b0;
   logic              rst, tick, wr_en;
   logic [4:0]        wr_addr;
   logic [7:0]        wr_data;
   logic [2:0][23:0]  phase;
   logic [2:0]        pulse;
   logic [2:0][11:0]  noise;
   logic              busy, frame_done, overrun;

   int n_tests, n_fail;

   logic [23:0] m_acc  [3];
   logic [22:0] m_lfsr [3];
   bit          m_rise [3];
   logic [15:0] m_freq [3];
   logic [11:0] m_pw   [3];
   logic [7:0]  m_ctrl [3];
   bit          m_ovr;

   osc_sched dut (
      .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .phase(phase), .pulse(pulse), .noise(noise),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int v = 0; v < 3; v++) begin
         m_acc[v] = 0; m_lfsr[v] = 23'h7FFFF8; m_rise[v] = 0;
         m_freq[v] = 0; m_pw[v] = 0; m_ctrl[v] = 0;
      end
      m_ovr = 0;
   endfunction

   function automatic void m_write(input int a, input logic [7:0] d);
      int v = a / 7;
      int off = a % 7;
      if (a < 21) begin
         case (off)
            0: m_freq[v][7:0]  = d;
            1: m_freq[v][15:8] = d;
            2: m_pw[v][7:0]    = d;
            3: m_pw[v][11:8]   = d[3:0];
            4: m_ctrl[v]       = d;
            default: ;
         endcase
      end
   endfunction

   function automatic void m_voice(input int v);
      int s = (v + 2) % 3;
      logic [23:0] o = m_acc[v];
      logic [23:0] n;
      if (m_ctrl[v][3]) begin
         n = 0;
         m_lfsr[v] = 23'h7FFFF8;
      end else if (m_ctrl[v][1] && m_rise[s]) begin
         n = 0;
      end else begin
         n = o + {8'd0, m_freq[v]};
         if (!o[19] && n[19]) m_lfsr[v] = {m_lfsr[v][21:0], m_lfsr[v][22] ^ m_lfsr[v][17]};
      end
      m_rise[v] = !o[23] && n[23];
      m_acc[v]  = n;
   endfunction

   task automatic check_all(input string tag);
      for (int v = 0; v < 3; v++) begin
         chk($sformatf("%s_phase%0d", tag, v), 32'(phase[v]), 32'(m_acc[v]));
         chk($sformatf("%s_noise%0d", tag, v), 32'(noise[v]), 32'(m_lfsr[v][22:11]));
         chk($sformatf("%s_pulse%0d", tag, v), 32'(pulse[v]), 32'(m_acc[v][23:12] >= m_pw[v]));
      end
      chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wr_en = 1; wr_addr = 5'(a); wr_data = d;
      @(negedge clk);
      wr_en = 0;
      m_write(a, d);
   endtask

   // One frame; optionally a register write is held during the update cycle of voice wv.
   task automatic frame(input int wv, input int wa, input logic [7:0] wd);
      int lat = 0;
      tick = 1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tick = 0;
         wr_en = (c == wv + 1);
         wr_addr = 5'(wa); wr_data = wd;
         if (frame_done) begin lat = c; break; end
      end
      wr_en = 0;
      chk("fd_latency", 32'(lat), 32'd4);
      @(negedge clk);
      chk("fd_width", 32'(frame_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      for (int v = 0; v < 3; v++) begin
         m_voice(v);
         if (v == wv) m_write(wa, wd);
      end
      check_all("frame");
   endtask

   task automatic do_reset();
      rst = 0;
      m_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
   endtask

   initial begin
      int fd, prev, found, a;
      logic [7:0] d;
      n_tests = 0; n_fail = 0;
      rst = 0; tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      m_reset();
      @(negedge clk);
      check_all("reset");
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_fd", 32'(frame_done), 32'd0);
      rst = 1;
      @(negedge clk);

      // freq 0 holds the accumulator; reserved and out-of-map writes do nothing
      wr(5, 8'hFF); wr(6, 8'hFF); wr(13, 8'hFF); wr(25, 8'hFF); wr(31, 8'hFF);
      frame(-1, 0, 0);

      // 16 frames at freq 0x1000
      wr(0, 8'h00); wr(1, 8'h10);
      repeat (16) frame(-1, 0, 0);
      chk("acc16", 32'(phase[0]), 32'h010000);

      // wrap modulo 2^24
      do_reset();
      wr(0, 8'hFF); wr(1, 8'hFF);
      repeat (256) frame(-1, 0, 0);
      wr(0, 8'hF0); wr(1, 8'h00);
      frame(-1, 0, 0);
      chk("preload", 32'(phase[0]), 32'hFFFFF0);
      wr(0, 8'hFF); wr(1, 8'hFF);
      frame(-1, 0, 0);
      chk("wrap", 32'(phase[0]), 32'h00FFEF);

      // hard sync of voice 1 from voice 0's MSB rise
      do_reset();
      wr(0, 8'h00); wr(1, 8'h80); wr(7, 8'h00); wr(8, 8'h01); wr(11, 8'h02);
      found = 0;
      for (int i = 0; i < 300; i++) begin
         prev = int'(phase[0][23]);
         frame(-1, 0, 0);
         if (prev == 0 && phase[0][23]) begin
            chk("sync_phase1", 32'(phase[1]), 32'd0);
            found = 1;
            break;
         end
      end
      chk("sync_found", 32'(found), 32'd1);

      // test bit on voice 2 mid-run
      do_reset();
      wr(14, 8'h55); wr(15, 8'h32);
      repeat (20) frame(-1, 0, 0);
      wr(18, 8'h08);
      frame(-1, 0, 0);
      chk("test_phase2", 32'(phase[2]), 32'd0);
      chk("test_noise2", 32'(noise[2]), 32'hFFF);
      wr(18, 8'h00);
      frame(-1, 0, 0);
      chk("test_resume", 32'(phase[2]), 32'h3255);

      // writes coinciding with voice updates
      frame(0, 0, 8'h77);
      frame(1, 15, 8'h01);
      frame(2, 1, 8'h02);

      // tick dropped while busy
      fd = 0;
      tick = 1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         tick = (c == 2);
         if (frame_done) fd++;
      end
      chk("ovr_fd_count", 32'(fd), 32'd1);
      m_ovr = 1;
      for (int v = 0; v < 3; v++) m_voice(v);
      check_all("ovr");

      // reset during V1 abandons the frame
      wr(0, 8'h11);
      tick = 1;
      @(negedge clk); tick = 0;
      @(negedge clk);
      rst = 0;
      m_reset();
      #1;
      check_all("rst_mid");
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      wr(0, 8'h34);
      frame(-1, 0, 0);
      chk("post_rst", 32'(phase[0]), 32'h34);

      // randomized register traffic and frames
      for (int i = 0; i < 300; i++) begin
         a = int'($urandom_range(0, 31));
         d = 8'($urandom);
         if (a % 7 == 4 && $urandom_range(0, 3) != 0) d[3] = 1'b0;
         case ($urandom_range(0, 3))
            0, 1: wr(a, d);
            2:    frame(-1, 0, 0);
            default: frame(int'($urandom_range(0, 2)), a, d);
         endcase
         if ($urandom_range(0, 7) == 0) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
